regwrite_sequencer: RTL and testbench

- Sequences register-file write-back for the multicycle datapath.
- Accepts one write-back request at a time from the main control unit and drives the write-data source select (`RegData`), the destination register number and the register-file write enable.
- Three sequence types:
  - single-cycle writes;
  - writes that must wait for a multicycle unit (mult/div, shifter) to finish;
  - the two-write XCHG sequence.
- Sits between the control unit and the register-file write port, alongside the write-data mux.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_wait_timer.sv | 28 ++
 rtl/regwrite_sequencer.sv | 140 ++++++++++++++
 tb/tb_regwrite_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register write-back sequencer: write-data source
// codes and the sequencer state encoding.
package wb_pkg;

    typedef logic [3:0] wb_src_t;

    localparam wb_src_t SRC_ALU      = 4'd0;
    localparam wb_src_t SRC_HILO     = 4'd1;
    localparam wb_src_t SRC_SEXT1    = 4'd2;
    localparam wb_src_t SRC_SHIFT    = 4'd3;
    localparam wb_src_t SRC_LOAD     = 4'd4;
    localparam wb_src_t SRC_LUI      = 4'd5;
    localparam wb_src_t SRC_CONST227 = 4'd6;
    localparam wb_src_t SRC_XCHG     = 4'd7;
    localparam wb_src_t SRC_REGA     = 4'd8;
    localparam wb_src_t SRC_MAX      = 4'd8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StWrite1 = 2'd2,
        StWrite2 = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_wait_timer.sv
// WAIT-state timeout counter. Holds at zero while not running, so it restarts
// on every WAIT entry; expired is high in the last allowed WAIT cycle.
module wb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (!run) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/regwrite_sequencer.sv
// Register-file write-back sequencer: single writes, writes gated by a
// multicycle unit, and the two-write XCHG. Define WB_TIMEOUT_EN to abort WAIT.
module regwrite_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic [4:0] wb_dst2,
    input  logic       wb_xchg,
    input  logic       wb_wait,
    input  logic       unit_done,
    output logic [3:0] RegData,
    output logic [4:0] WriteReg,
    output logic       RegWrite,
    output logic       wb_busy,
    output logic       wb_ack,
    output logic       wb_err
);

    wb_state_e state_q, state_d;
    wb_src_t   src_q, src_d;
    logic [4:0] dst_q, dst_d;
    logic [4:0] dst2_q, dst2_d;
    logic       xchg_q, xchg_d;
    logic       err_q, err_d;
    logic       timeout_hit;
    logic       write_cycle;

`ifdef WB_TIMEOUT_EN
    logic timer_expired;

    wb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == StWait),
        .expired(timer_expired)
    );

    // A result arriving in the last allowed cycle still wins over the abort.
    assign timeout_hit = timer_expired & ~unit_done;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            dst2_q  <= '0;
            xchg_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            dst2_q  <= dst2_d;
            xchg_q  <= xchg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dst2_d  = dst2_q;
        xchg_d  = xchg_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_req) begin
                    src_d  = wb_src;
                    dst_d  = wb_dst;
                    dst2_d = wb_dst2;
                    xchg_d = wb_xchg;
                    if (wb_src > SRC_MAX) begin
                        err_d = 1'b1;
                    end else if (wb_wait) begin
                        state_d = StWait;
                    end else begin
                        state_d = StWrite1;
                    end
                end
            end
            StWait: begin
                if (unit_done) begin
                    state_d = StWrite1;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StWrite1: state_d = xchg_q ? StWrite2 : StIdle;
            StWrite2: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        RegData     = '0;
        WriteReg    = '0;
        write_cycle = 1'b0;
        wb_ack      = 1'b0;
        unique case (state_q)
            StWrite1: begin
                WriteReg    = dst_q;
                write_cycle = 1'b1;
                if (xchg_q) begin
                    RegData = SRC_XCHG;
                end else begin
                    RegData = src_q;
                    wb_ack  = 1'b1;
                end
            end
            StWrite2: begin
                RegData     = SRC_REGA;
                WriteReg    = dst2_q;
                write_cycle = 1'b1;
                wb_ack      = 1'b1;
            end
            default: ;
        endcase
    end

    // $0 is hardwired; suppress the enable but keep the sequence timing.
    assign RegWrite = write_cycle && (WriteReg != 5'd0);
    assign wb_busy  = (state_q != StIdle);
    assign wb_err   = err_q;

endmodule

// File: tb/tb_regwrite_sequencer.sv
// Scoreboard bench for regwrite_sequencer: stimulus pushes expected output
// beats with their cycle numbers; a negedge monitor pops and compares.
module tb_regwrite_sequencer;

    typedef struct packed {
        logic [3:0]  rd;
        logic [4:0]  wr;
        logic        we;
        logic        ack;
        logic        err;
        logic [31:0] cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       wb_req;
    logic [3:0] wb_src;
    logic [4:0] wb_dst;
    logic [4:0] wb_dst2;
    logic       wb_xchg;
    logic       wb_wait;
    logic       unit_done;
    logic [3:0] RegData;
    logic [4:0] WriteReg;
    logic       RegWrite;
    logic       wb_busy;
    logic       wb_ack;
    logic       wb_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    ev_t         exp_q[$];

    regwrite_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .wb_req   (wb_req),
        .wb_src   (wb_src),
        .wb_dst   (wb_dst),
        .wb_dst2  (wb_dst2),
        .wb_xchg  (wb_xchg),
        .wb_wait  (wb_wait),
        .unit_done(unit_done),
        .RegData  (RegData),
        .WriteReg (WriteReg),
        .RegWrite (RegWrite),
        .wb_busy  (wb_busy),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: any non-idle output pattern is a beat that must match the queue head.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        if (rst_n && (RegWrite || wb_ack || wb_err || RegData != 4'd0 || WriteReg != 5'd0)) begin
            act = '{rd: RegData, wr: WriteReg, we: RegWrite, ack: wb_ack, err: wb_err, cyc: cyc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got rd=%0d wr=%0d we=%0d ack=%0d err=%0d cyc=%0d, required none",
                         act.rd, act.wr, act.we, act.ack, act.err, act.cyc);
            end else begin
                exp = exp_q.pop_front();
                if (act != exp) begin
                    errors++;
                    $display("FAIL beat: got rd=%0d wr=%0d we=%0d ack=%0d err=%0d cyc=%0d, required rd=%0d wr=%0d we=%0d ack=%0d err=%0d cyc=%0d",
                             act.rd, act.wr, act.we, act.ack, act.err, act.cyc,
                             exp.rd, exp.wr, exp.we, exp.ack, exp.err, exp.cyc);
                end
            end
        end
    end

    task automatic push(input logic [3:0] rd, input logic [4:0] wr, input logic we,
                        input logic ack, input logic err, input logic [31:0] c);
        exp_q.push_back('{rd: rd, wr: wr, we: we, ack: ack, err: err, cyc: c});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns k, the cycle before acceptance.
    task automatic issue(input logic [3:0] src, input logic [4:0] dst, input logic [4:0] dst2,
                         input logic xchg, input logic wt, output logic [31:0] k);
        wb_src  = src;
        wb_dst  = dst;
        wb_dst2 = dst2;
        wb_xchg = xchg;
        wb_wait = wt;
        wb_req  = 1'b1;
        k       = cyc;
        step(1);
        wb_req  = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {18'd0, RegData, WriteReg, RegWrite, wb_ack, wb_err, wb_busy};
    endfunction

    initial begin
        logic [31:0] k;
        rst_n     = 1'b0;
        wb_req    = 1'b0;
        wb_src    = '0;
        wb_dst    = '0;
        wb_dst2   = '0;
        wb_xchg   = 1'b0;
        wb_wait   = 1'b0;
        unit_done = 1'b0;
        step(3);
        check("reset_outputs", outs(), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("post_reset_outputs", outs(), 32'd0);

        // Single write src=0 dst=5
        issue(4'd0, 5'd5, 5'd0, 1'b0, 1'b0, k);
        push(4'd0, 5'd5, 1'b1, 1'b1, 1'b0, k + 1);
        check("single_busy", 32'(wb_busy), 32'd1);
        step(1);
        check("single_idle_outputs", outs(), 32'd0);

        // XCHG dst=3 dst2=9; latched src ignored
        issue(4'd4, 5'd3, 5'd9, 1'b1, 1'b0, k);
        push(4'd7, 5'd3, 1'b1, 1'b0, 1'b0, k + 1);
        push(4'd8, 5'd9, 1'b1, 1'b1, 1'b0, k + 2);
        step(2);
        check("xchg_idle_outputs", outs(), 32'd0);

        // Wait write: unit_done raised in the 10th cycle after acceptance
        issue(4'd1, 5'd4, 5'd0, 1'b0, 1'b1, k);
        for (int i = 0; i < 9; i++) begin
            check("wait_busy", 32'(wb_busy), 32'd1);
            check("wait_no_write", 32'(RegWrite), 32'd0);
            step(1);
        end
        unit_done = 1'b1;
        push(4'd1, 5'd4, 1'b1, 1'b1, 1'b0, k + 11);
        step(1);
        unit_done = 1'b0;
        check("wait_write_busy", 32'(wb_busy), 32'd1);
        step(1);
        check("wait_idle", 32'(wb_busy), 32'd0);

        // Illegal source code
        issue(4'd12, 5'd6, 5'd0, 1'b0, 1'b0, k);
        push(4'd0, 5'd0, 1'b0, 1'b0, 1'b1, k + 1);
        check("illegal_not_busy", 32'(wb_busy), 32'd0);
        step(1);

        // Destination $0: ack without enable
        issue(4'd2, 5'd0, 5'd0, 1'b0, 1'b0, k);
        push(4'd2, 5'd0, 1'b0, 1'b1, 1'b0, k + 1);
        step(1);

        // Request held across the ack cycle: next acceptance two cycles later
        k       = cyc;
        wb_src  = 4'd5;
        wb_dst  = 5'd12;
        wb_xchg = 1'b0;
        wb_wait = 1'b0;
        wb_req  = 1'b1;
        push(4'd5, 5'd12, 1'b1, 1'b1, 1'b0, k + 1);
        push(4'd5, 5'd12, 1'b1, 1'b1, 1'b0, k + 3);
        step(3);
        wb_req = 1'b0;
        step(1);

        // Wait + XCHG with unit_done already high: one WAIT cycle
        unit_done = 1'b1;
        issue(4'd0, 5'd10, 5'd11, 1'b1, 1'b1, k);
        push(4'd7, 5'd10, 1'b1, 1'b0, 1'b0, k + 2);
        push(4'd8, 5'd11, 1'b1, 1'b1, 1'b0, k + 3);
        step(3);
        unit_done = 1'b0;
        check("wait_xchg_idle", 32'(wb_busy), 32'd0);

        // Reset during WAIT
        issue(4'd3, 5'd4, 5'd0, 1'b0, 1'b1, k);
        step(1);
        rst_n = 1'b0;
        #1;
        check("reset_in_wait", outs(), 32'd0);
        step(1);
        rst_n     = 1'b1;
        unit_done = 1'b1;
        step(3);
        unit_done = 1'b0;
        check("after_wait_reset", outs(), 32'd0);

        // Reset during WRITE2 of an XCHG
        issue(4'd0, 5'd7, 5'd8, 1'b1, 1'b0, k);
        push(4'd7, 5'd7, 1'b1, 1'b0, 1'b0, k + 1);
        step(1);
        rst_n = 1'b0;
        #1;
        check("reset_in_write2", outs(), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("after_write2_reset", outs(), 32'd0);

`ifdef WB_TIMEOUT_EN
        // Timeout: 8 WAIT cycles, then error pulse in IDLE
        issue(4'd0, 5'd6, 5'd0, 1'b0, 1'b1, k);
        push(4'd0, 5'd0, 1'b0, 1'b0, 1'b1, k + 9);
        step(7);
        check("timeout_still_busy", 32'(wb_busy), 32'd1);
        step(1);
        check("timeout_idle", 32'(wb_busy), 32'd0);
        step(3);
`endif

        step(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
